// File: rtl/dcsk_frame_sequencer.sv
// DCSK frame sequencer: walks bit/chip indices through one frame of N bits, each
// spread over 2*SF chips, with a start/busy/done handshake, abort and config checking.
module dcsk_frame_sequencer #(
    parameter int MIN_SF_LOG2 = 1,
    parameter int MAX_SF_LOG2 = 4,
    parameter int MAX_BITS    = 1024,
    localparam int CHIP_W     = MAX_SF_LOG2 + 1,
    localparam int BIT_W      = $clog2(MAX_BITS),
    localparam int LEN_W      = $clog2(MAX_BITS + 1)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [2:0]        i_sf_log2,
    input  logic [LEN_W-1:0]  i_frame_len,
    input  logic              i_chip_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cfg_err,
    output logic [BIT_W-1:0]  o_bit_index,
    output logic [CHIP_W-1:0] o_chip_index,
    output logic              o_data_half,
    output logic              o_bit_strobe,
    output logic              o_last_chip
);

    localparam logic [2:0]       MIN_SF  = 3'(MIN_SF_LOG2);
    localparam logic [2:0]       MAX_SF  = 3'(MAX_SF_LOG2);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        sf_reg, sf_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [BIT_W-1:0]  bit_reg, bit_next;
    logic [CHIP_W-1:0] chip_reg, chip_next;
    logic              cfg_err_reg, cfg_err_next;

    logic [CHIP_W-1:0] chip_max;
    logic              at_wrap;
    logic              last_bit;
    logic              cfg_legal;
    logic              run;

    // Last chip index of a bit is 2*SF-1: every bit at or below the latched sf set.
    for (genvar gi = 0; gi < CHIP_W; gi++) begin : g_chip_max
        assign chip_max[gi] = (3'(gi) <= sf_reg);
    end

    assign at_wrap   = (chip_reg == chip_max);
    assign last_bit  = (LEN_W'(bit_reg) == (len_reg - LEN_W'(1)));
    assign cfg_legal = (i_sf_log2 >= MIN_SF) && (i_sf_log2 <= MAX_SF) &&
                       (i_frame_len != '0) && (i_frame_len <= MAX_LEN);
    assign run       = (state_reg == ST_RUN);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_reg   <= ST_IDLE;
            sf_reg      <= '0;
            len_reg     <= '0;
            bit_reg     <= '0;
            chip_reg    <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sf_reg      <= sf_next;
            len_reg     <= len_next;
            bit_reg     <= bit_next;
            chip_reg    <= chip_next;
            cfg_err_reg <= cfg_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sf_next      = sf_reg;
        len_next     = len_reg;
        bit_next     = bit_reg;
        chip_next    = chip_reg;
        cfg_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!i_abort && i_start) begin
                    if (cfg_legal) begin
                        sf_next    = i_sf_log2;
                        len_next   = i_frame_len;
                        bit_next   = '0;
                        chip_next  = '0;
                        state_next = ST_RUN;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    bit_next   = '0;
                    chip_next  = '0;
                    state_next = ST_IDLE;
                end else if (i_chip_en) begin
                    if (!at_wrap) begin
                        chip_next = chip_reg + CHIP_W'(1);
                    end else if (!last_bit) begin
                        chip_next = '0;
                        bit_next  = bit_reg + BIT_W'(1);
                    end else begin
                        bit_next   = '0;
                        chip_next  = '0;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                bit_next   = '0;
                chip_next  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_busy       = run;
    assign o_done       = (state_reg == ST_DONE);
    assign o_cfg_err    = cfg_err_reg;
    assign o_bit_index  = bit_reg;
    assign o_chip_index = chip_reg;
    assign o_data_half  = run && chip_reg[sf_reg];
    assign o_bit_strobe = run && i_chip_en && (chip_reg == '0);
    assign o_last_chip  = run && at_wrap && last_bit;

endmodule

// File: tb/tb_dcsk_frame_sequencer.sv
// Scoreboard bench for dcsk_frame_sequencer: the driver predicts each chip tick, done
// and cfg_err event from frame arithmetic; a negedge monitor pops and compares.
module tb_dcsk_frame_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start, abort, chip_en;
    logic [2:0]  sf_log2;
    logic [10:0] frame_len;
    logic        busy, done, cfg_err, data_half, bit_strobe, last_chip;
    logic [9:0]  bit_index;
    logic [4:0]  chip_index;

    always #5 clk = ~clk;

    dcsk_frame_sequencer dut (
        .i_clk        (clk),
        .i_arst_n     (arst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_sf_log2    (sf_log2),
        .i_frame_len  (frame_len),
        .i_chip_en    (chip_en),
        .o_busy       (busy),
        .o_done       (done),
        .o_cfg_err    (cfg_err),
        .o_bit_index  (bit_index),
        .o_chip_index (chip_index),
        .o_data_half  (data_half),
        .o_bit_strobe (bit_strobe),
        .o_last_chip  (last_chip)
    );

    localparam int K_TICK = 0, K_DONE = 1, K_CFGERR = 2;

    typedef struct {
        int kind;
        int bit_i;
        int chip;
        bit half;
        bit strobe;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   exp_busy    = 1'b0;

    function automatic void push(int k, int b, int c, bit h, bit s, bit l);
        exp_t e;
        e.kind = k; e.bit_i = b; e.chip = c; e.half = h; e.strobe = s; e.last = l;
        exp_q.push_back(e);
    endfunction

    function automatic void pop_check(int k);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event_kind: got event %0d with no expectation queued, required none", k);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            miscompares++;
            $display("FAIL event_kind: got event %0d, required event %0d", k, e.kind);
        end else if (k == K_TICK) begin
            if (bit_index !== 10'(e.bit_i) || chip_index !== 5'(e.chip) ||
                data_half !== e.half || bit_strobe !== e.strobe || last_chip !== e.last) begin
                miscompares++;
                $display("FAIL tick: got bit=%0d chip=%0d half=%0b strobe=%0b last=%0b, required bit=%0d chip=%0d half=%0b strobe=%0b last=%0b",
                         bit_index, chip_index, data_half, bit_strobe, last_chip,
                         e.bit_i, e.chip, e.half, e.strobe, e.last);
            end
        end
    endfunction

    function automatic void check_zero(string name);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || bit_index !== '0 ||
            chip_index !== '0 || data_half !== 1'b0 || bit_strobe !== 1'b0 || last_chip !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got busy=%0b done=%0b cfg_err=%0b bit=%0d chip=%0d half=%0b strobe=%0b last=%0b, required all 0",
                     name, busy, done, cfg_err, bit_index, chip_index, data_half, bit_strobe, last_chip);
        end
    endfunction

    // Monitor: samples 1 time unit after the falling edge, when inputs are settled.
    always @(negedge clk) begin
        #1;
        if (arst_n) begin
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL busy: got %0b, required %0b", busy, exp_busy);
            end
            if (busy && chip_en && !abort) pop_check(K_TICK);
            if (done)    pop_check(K_DONE);
            if (cfg_err) pop_check(K_CFGERR);
            if (!busy) begin
                vectors++;
                if (bit_index !== '0 || chip_index !== '0 || data_half !== 1'b0 ||
                    bit_strobe !== 1'b0 || last_chip !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_outputs: got bit=%0d chip=%0d half=%0b strobe=%0b last=%0b, required all 0",
                             bit_index, chip_index, data_half, bit_strobe, last_chip);
                end
            end
        end
    end

    task automatic frame_end_check(string name);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pending: got %0d unobserved expected events, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic run_frame(input int sf, input int len, input int en_pct,
                             input int abort_at, input int reset_at, input bit tamper);
        int span, total, t;
        bit legal;
        @(negedge clk);
        start     = 1'b1;
        abort     = 1'b0;
        sf_log2   = 3'(sf);
        frame_len = 11'(len);
        chip_en   = 1'($urandom_range(0, 1));
        exp_busy  = 1'b0;
        legal     = (sf >= 1) && (sf <= 4) && (len >= 1) && (len <= 1024);
        @(negedge clk);
        start   = 1'b0;
        chip_en = 1'b0;
        if (!legal) begin
            push(K_CFGERR, 0, 0, 0, 0, 0);
            $display("frame sf_log2=%0d len=%0d: rejected, cfg_err expected", sf, len);
            frame_end_check("cfg");
            return;
        end
        span     = 2 << sf;
        total    = len * span;
        t        = 0;
        exp_busy = 1'b1;
        while (t < total) begin
            if (t == abort_at) begin
                abort   = 1'b1;
                chip_en = 1'($urandom_range(0, 1));
                @(negedge clk);
                abort    = 1'b0;
                start    = 1'b0;
                chip_en  = 1'b0;
                exp_busy = 1'b0;
                $display("frame sf_log2=%0d len=%0d: aborted at tick %0d", sf, len, t);
                frame_end_check("abort");
                return;
            end
            if (tamper) begin
                start     = 1'($urandom_range(0, 1));
                sf_log2   = 3'($urandom);
                frame_len = 11'($urandom);
            end
            chip_en = ($urandom_range(0, 99) < en_pct);
            if (t == reset_at) chip_en = 1'b1;
            if (chip_en)
                push(K_TICK, t / span, t % span, (t % span) >= span / 2,
                     (t % span) == 0, t == total - 1);
            if (t == reset_at) begin
                #3 arst_n = 1'b0;
                #1 check_zero("async_reset");
                exp_busy = 1'b0;
                chip_en  = 1'b0;
                start    = 1'b0;
                @(negedge clk);
                #2 arst_n = 1'b1;
                $display("frame sf_log2=%0d len=%0d: reset at bit %0d chip %0d", sf, len, t / span, t % span);
                frame_end_check("reset");
                return;
            end
            if (chip_en) t++;
            @(negedge clk);
        end
        exp_busy  = 1'b0;
        push(K_DONE, 0, 0, 0, 0, 0);
        start     = 1'($urandom_range(0, 1));
        sf_log2   = 3'd1;
        frame_len = 11'd1;
        chip_en   = 1'($urandom_range(0, 1));
        @(negedge clk);
        start   = 1'b0;
        chip_en = 1'b0;
        $display("frame sf_log2=%0d len=%0d: %0d chips, done expected", sf, len, total);
        frame_end_check("done");
    endtask

    task automatic idle_abort_start(input int sf, input int len);
        @(negedge clk);
        start     = 1'b1;
        abort     = 1'b1;
        sf_log2   = 3'(sf);
        frame_len = 11'(len);
        chip_en   = 1'b1;
        exp_busy  = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        chip_en = 1'b0;
        $display("idle abort+start sf_log2=%0d len=%0d: stays idle", sf, len);
        frame_end_check("idle_abort");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish within time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sf, len, ab;
        arst_n    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        chip_en   = 1'b0;
        sf_log2   = 3'd0;
        frame_len = 11'd0;
        repeat (2) @(negedge clk);
        #1 check_zero("reset_state");
        #1 arst_n = 1'b1;

        run_frame(1, 3, 100, -1, -1, 0);
        run_frame(2, 8, 100, -1, 29, 0);
        run_frame(2, 2, 100, -1, -1, 0);
        run_frame(0, 5, 100, -1, -1, 0);
        run_frame(5, 5, 100, -1, -1, 0);
        run_frame(7, 5, 100, -1, -1, 0);
        run_frame(2, 0, 100, -1, -1, 0);
        run_frame(2, 1025, 100, -1, -1, 0);
        run_frame(3, 4, 80, 33, -1, 0);
        run_frame(3, 4, 100, -1, -1, 0);
        run_frame(1, 2, 100, 0, -1, 0);
        run_frame(1, 2, 100, 7, -1, 0);
        run_frame(4, 1, 60, -1, -1, 0);
        run_frame(2, 5, 70, -1, -1, 1);
        idle_abort_start(2, 4);
        idle_abort_start(0, 4);
        run_frame(4, 1024, 70, -1, -1, 0);

        for (int i = 0; i < 20; i++) begin
            sf  = $urandom_range(0, 5);
            len = $urandom_range(0, 16);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len * (2 << sf)) : -1;
            run_frame(sf, len, $urandom_range(50, 100), ab, -1, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        frame_end_check("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
